serial_adder_ctrl: RTL and testbench

- Bit-serial multi-bit adder controller. It time-shares one Full_Adder instance (port order sum, c_out, a, b, c_in) across WIDTH cycles, LSB first.
- Provides a start/done handshake, operand capture, carry sequencing and a stable registered result.
- Sits between a requesting FSM/datapath and the single-bit adder slice; trades area for WIDTH-cycle latency.

---
 rtl/serial_adder_ctrl.sv | 147 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller sharing one Full_Adder slice, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_sum;
    logic fa_cout;

    Full_Adder u_fa (
        .sum   (fa_sum),
        .c_out (fa_cout),
        .a     (op_a_q[0]),
        .b     (op_b_q[0]),
        .c_in  (carry_q)
    );

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = c_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
                op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    sum_d   = res_d;
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final edge
                    ovf_d   = carry_q ^ fa_cout;
`endif
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign sum   = sum_q;
    assign c_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// Single-bit full adder slice.
module Full_Adder (
    output logic sum,
    output logic c_out,
    input  logic a,
    input  logic b,
    input  logic c_in
);
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); expected {ovf,c_out,sum} queued at issue.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       c_in;
    logic       busy, done;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf_obs;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    logic [9:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .c_out (c_out),
        .ovf   (ovf)
`else
        .c_out (c_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] r;
        logic       o;
        r = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        o = (x[7] == y[7]) && (r[7] != x[7]);
`ifndef SERIAL_ADDER_OVF_EN
        o = 1'b0;
`endif
        return {o, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start with operands through one edge and queue the expected result.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic);
        a = ia; b = ib; c_in = ic; start = 1'b1;
        tick();
        exp_q.push_back(model(ia, ib, ic));
    endtask

    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    function automatic logic [9:0] pop_exp();
        if (exp_q.size() == 0) return 10'h3FF;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({busy, done, c_out, sum} !== 11'd0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: busy=%b done=%b c_out=%b sum=%h, want all 0",
                         i, busy, done, c_out, sum);
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int n; bit bok; logic [9:0] e; logic [8:0] held;
        issue(8'h0F, 8'h01, 1'b0);
        start = 1'b0;
        wait_done(n, bok);
        tests++;
        if (n !== 8 || !bok) begin
            fails++;
            $display("FAIL basic_latency: done after %0d edges busy_ok=%0d, want 8 and 1", n, bok);
        end
        e = pop_exp();
        tests++;
        if ({ovf_obs, c_out, sum} !== e || busy !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: got %h busy=%b, want %h busy=0", {ovf_obs, c_out, sum}, busy, e);
        end
        held = {c_out, sum};
        tick();
        tests++;
        if (done !== 1'b0 || {c_out, sum} !== 9'h010 || {c_out, sum} !== held) begin
            fails++;
            $display("FAIL basic_hold: done=%b result=%h, want done=0 result=010", done, {c_out, sum});
        end
    endtask

    task automatic test_carry_chain();
        int n; bit bok; logic [9:0] e;
        issue(8'hFF, 8'h01, 1'b0);
        start = 1'b0;
        wait_done(n, bok);
        e = pop_exp();
        tests++;
        if (n !== 8 || {ovf_obs, c_out, sum} !== e) begin
            fails++;
            $display("FAIL carry_ff_01: n=%0d got %h, want n=8 %h", n, {ovf_obs, c_out, sum}, e);
        end
        tick();
        // start stays high across DONE: two operations back to back
        issue(8'hFF, 8'hFF, 1'b1);
        wait_done(n, bok);
        e = pop_exp();
        tests++;
        if (n !== 8 || {ovf_obs, c_out, sum} !== e) begin
            fails++;
            $display("FAIL b2b_first: n=%0d got %h, want n=8 %h", n, {ovf_obs, c_out, sum}, e);
        end
        tick();
        exp_q.push_back(model(8'hFF, 8'hFF, 1'b1));
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b, want 1", busy);
        end
        start = 1'b0;
        wait_done(n, bok);
        e = pop_exp();
        tests++;
        if (n + 1 !== 9 || !bok || {ovf_obs, c_out, sum} !== e) begin
            fails++;
            $display("FAIL b2b_second: spacing=%0d got %h, want 9 %h", n + 1, {ovf_obs, c_out, sum}, e);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_ignore_abort();
        int n; bit bok; logic [9:0] e; bit seen;
        issue(8'h10, 8'h20, 1'b0);
        start = 1'b0;
        tick(); tick();
        start = 1'b1; a = 8'h55;
        tick();
        start = 1'b0;
        wait_done(n, bok);
        e = pop_exp();
        tests++;
        if (n + 3 !== 8 || {ovf_obs, c_out, sum} !== e) begin
            fails++;
            $display("FAIL ignore_start: n=%0d got %h, want n=8 %h", n + 3, {ovf_obs, c_out, sum}, e);
        end
        tick();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL ignore_no_requeue: busy=%b, want 0", busy);
        end
        issue(8'h11, 8'h22, 1'b0);
        void'(exp_q.pop_back());
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        tests++;
        if ({busy, done, c_out, sum} !== 11'd0) begin
            fails++;
            $display("FAIL abort_cleared: busy=%b done=%b result=%h, want 0 0 000", busy, done, {c_out, sum});
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL abort_no_done: activity seen=%0d, want 0", seen);
        end
    endtask

    task automatic test_stability();
        int n; logic [9:0] e;
        issue(8'hA5, 8'h5A, 1'b1);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            a = 8'($urandom); b = 8'($urandom); c_in = 1'($urandom);
            tick();
            n++;
        end
        e = pop_exp();
        tests++;
        if (n !== 8 || {c_out, sum} !== 9'h100 || {ovf_obs, c_out, sum} !== e) begin
            fails++;
            $display("FAIL operand_stability: n=%0d got %h, want n=8 %h", n, {ovf_obs, c_out, sum}, e);
        end
        tick();
    endtask

    task automatic test_random();
        int n; bit bok; logic [9:0] e;
        for (int i = 0; i < 6; i++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom));
            start = 1'b0;
            wait_done(n, bok);
            e = pop_exp();
            tests++;
            if (n !== 8 || !bok || {ovf_obs, c_out, sum} !== e) begin
                fails++;
                $display("FAIL random_%0d: n=%0d got %h, want n=8 %h", i, n, {ovf_obs, c_out, sum}, e);
            end
            tick();
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int n; bit bok; logic [9:0] e;
        logic [7:0] xa[3] = '{8'h7F, 8'h80, 8'hFF};
        logic [7:0] xb[3] = '{8'h01, 8'h80, 8'h01};
        logic [9:0] want[3] = '{10'h280, 10'h300, 10'h100};
        for (int i = 0; i < 3; i++) begin
            issue(xa[i], xb[i], 1'b0);
            start = 1'b0;
            wait_done(n, bok);
            e = pop_exp();
            tests++;
            if ({ovf, c_out, sum} !== want[i] || {ovf, c_out, sum} !== e) begin
                fails++;
                $display("FAIL ovf_%0d: got %h, want %h", i, {ovf, c_out, sum}, want[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        test_reset();
        test_basic();
        test_carry_chain();
        test_ignore_abort();
        test_stability();
        test_random();
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
